alu_core: RTL and testbench

ALU_CORE -- requirements
Module: alu_core

---
 rtl/alu_core.sv | 118 +++++++++++
 tb/tb_alu_core.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// Single-cycle 8-bit ALU with registered result, status flags and valid strobe.
// Operands are captured only on enabled edges; flags follow the registered result.
module alu_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] op,
    output logic [7:0] result,
    output logic [7:0] flags,
    output logic       valid
);

    typedef enum logic [7:0] {
        OP_ADD  = 8'h00,
        OP_SUB  = 8'h01,
        OP_AND  = 8'h02,
        OP_OR   = 8'h03,
        OP_XOR  = 8'h04,
        OP_NOT  = 8'h05,
        OP_SHL  = 8'h06,
        OP_SHR  = 8'h07,
        OP_INC  = 8'h08,
        OP_DEC  = 8'h09,
        OP_EQ   = 8'h0A,
        OP_LTU  = 8'h0B,
        OP_GTU  = 8'h0C,
        OP_MUL  = 8'h0D,
        OP_PASA = 8'h0E,
        OP_PASB = 8'h0F
    } op_e;

    logic [8:0]  sum;
    logic [8:0]  dif;
    logic [8:0]  inc;
    logic [8:0]  dec;
    logic [15:0] prod;
    logic [7:0]  res_n;
    logic        c_n;
    logic        v_n;
    logic        ill_n;

    always_comb begin
        sum  = {1'b0, a} + {1'b0, b};
        dif  = {1'b0, a} - {1'b0, b};
        inc  = {1'b0, a} + 9'd1;
        dec  = {1'b0, a} - 9'd1;
        prod = {8'h00, a} * {8'h00, b};
    end

    always_comb begin
        res_n = 8'h00;
        c_n   = 1'b0;
        v_n   = 1'b0;
        ill_n = 1'b0;
        case (op)
            OP_ADD: begin
                res_n = sum[7:0];
                c_n   = sum[8];
                v_n   = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            OP_SUB: begin
                res_n = dif[7:0];
                c_n   = dif[8];
                v_n   = (a[7] != b[7]) && (dif[7] != a[7]);
            end
            OP_AND:  res_n = a & b;
            OP_OR:   res_n = a | b;
            OP_XOR:  res_n = a ^ b;
            OP_NOT:  res_n = ~a;
            OP_SHL: begin
                res_n = {a[6:0], 1'b0};
                c_n   = a[7];
            end
            OP_SHR: begin
                res_n = {1'b0, a[7:1]};
                c_n   = a[0];
            end
            OP_INC: begin
                res_n = inc[7:0];
                c_n   = inc[8];
                v_n   = (a == 8'h7F);
            end
            OP_DEC: begin
                res_n = dec[7:0];
                c_n   = dec[8];
                v_n   = (a == 8'h80);
            end
            OP_EQ:   res_n = {7'd0, a == b};
            OP_LTU:  res_n = {7'd0, a < b};
            OP_GTU:  res_n = {7'd0, a > b};
            OP_MUL: begin
                res_n = prod[7:0];
                c_n   = |prod[15:8];
            end
            OP_PASA: res_n = a;
            OP_PASB: res_n = b;
            // Unassigned opcodes yield zero so Z is set alongside ILL.
            default: ill_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= 8'h00;
            flags  <= 8'h00;
            valid  <= 1'b0;
        end else begin
            valid <= en;
            if (en) begin
                result <= res_n;
                flags  <= {3'b000, ill_n, v_n, res_n[7], c_n, res_n == 8'h00};
            end
        end
    end

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: stimulus queues expectations,
// a negedge monitor pops and compares whenever valid is seen.
module tb_alu_core;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] result;
    logic [7:0] flags;
    logic       valid;

    int total = 0;
    int bad   = 0;

    logic [15:0] sb_q[$];

    alu_core dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result),
        .flags  (flags),
        .valid  (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got r=%h f=%h, want none",
                         result, flags);
            end else begin
                check("scoreboard", {result, flags}, sb_q.pop_front());
            end
        end
    end

    task automatic send(input logic [7:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic push,
                        input logic [7:0] er, input logic [7:0] ef);
        en = 1'b1;
        op = o;
        a  = x;
        b  = y;
        if (push) sb_q.push_back({er, ef});
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain;
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 10) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        rst = 1'b0;
        en  = 1'b0;
        a   = 8'h00;
        b   = 8'h00;
        op  = 8'h00;
        #1 rst = 1'b1;
        #1;
        check("reset_async", {result, flags}, 16'h0000);
        check("reset_valid", {15'd0, valid}, 16'h0000);
        #1 rst = 1'b0;

        idle(3);
        check("hold_idle", {result, flags}, 16'h0000);
        check("idle_valid", {15'd0, valid}, 16'h0000);

        send(8'h00, 8'hFF, 8'h01, 1'b1, 8'h00, 8'h03);
        check("valid_high", {15'd0, valid}, 16'h0001);
        idle(1);
        check("valid_one_cycle", {15'd0, valid}, 16'h0000);
        send(8'h00, 8'h7F, 8'h01, 1'b1, 8'h80, 8'h0C);
        idle(1);
        send(8'h01, 8'h05, 8'h07, 1'b1, 8'hFE, 8'h06);
        send(8'h0A, 8'h2A, 8'h2A, 1'b1, 8'h01, 8'h00);
        send(8'h06, 8'h81, 8'h55, 1'b1, 8'h02, 8'h02);
        send(8'h40, 8'h12, 8'h34, 1'b1, 8'h00, 8'h11);
        drain();

        a = 8'hC3;
        b = 8'h3C;
        op = 8'h00;
        idle(3);
        check("hold_after_illegal", {result, flags}, 16'h0011);
        check("hold_valid", {15'd0, valid}, 16'h0000);

        send(8'h02, 8'hF0, 8'h3C, 1'b1, 8'h30, 8'h00);
        send(8'h03, 8'h00, 8'h00, 1'b1, 8'h00, 8'h01);
        send(8'h04, 8'hFF, 8'h0F, 1'b1, 8'hF0, 8'h04);
        send(8'h05, 8'h0F, 8'hAA, 1'b1, 8'hF0, 8'h04);
        send(8'h05, 8'h0F, 8'h00, 1'b1, 8'hF0, 8'h04);
        send(8'h07, 8'h81, 8'hFF, 1'b1, 8'h40, 8'h02);
        send(8'h08, 8'hFF, 8'h77, 1'b1, 8'h00, 8'h03);
        send(8'h08, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h0C);
        send(8'h09, 8'h00, 8'hFF, 1'b1, 8'hFF, 8'h06);
        send(8'h09, 8'h80, 8'h01, 1'b1, 8'h7F, 8'h08);
        send(8'h0B, 8'h03, 8'h04, 1'b1, 8'h01, 8'h00);
        send(8'h0C, 8'h03, 8'h04, 1'b1, 8'h00, 8'h01);
        send(8'h0D, 8'h10, 8'h10, 1'b1, 8'h00, 8'h03);
        send(8'h0D, 8'h07, 8'h06, 1'b1, 8'h2A, 8'h00);
        send(8'h0E, 8'h85, 8'h11, 1'b1, 8'h85, 8'h04);
        send(8'h0F, 8'h85, 8'h00, 1'b1, 8'h00, 8'h01);
        send(8'h01, 8'h80, 8'h01, 1'b1, 8'h7F, 8'h08);
        send(8'h00, 8'h80, 8'h80, 1'b1, 8'h00, 8'h0B);
        send(8'hFF, 8'h01, 8'h01, 1'b1, 8'h00, 8'h11);
        drain();

        send(8'h0E, 8'h5A, 8'h00, 1'b0, 8'h00, 8'h00);
        check("pre_reset_valid", {15'd0, valid}, 16'h0001);
        #2 rst = 1'b1;
        #1;
        check("midstream_reset", {result, flags}, 16'h0000);
        check("midstream_valid", {15'd0, valid}, 16'h0000);
        send(8'h0E, 8'h33, 8'h00, 1'b0, 8'h00, 8'h00);
        check("rst_over_en", {result, flags}, 16'h0000);
        rst = 1'b0;
        idle(2);
        check("post_reset_idle", {result, flags}, 16'h0000);
        send(8'h00, 8'h01, 8'h02, 1'b1, 8'h03, 8'h00);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
